// File: rtl/irq_ctrl.sv
// irq_ctrl: latches interrupt codes, requests the highest-priority enabled one,
// and tracks a single in-service interrupt until end-of-interrupt.
// Optional feature macro: IRQ_MASK_EN adds a loadable mask register with
// MASK_WE/MASK_DIN ports. Without it every code is always enabled.
module irq_ctrl #(
  parameter logic [15:0] VEC_BASE  = 16'hFF00,
  parameter int unsigned VEC_SHIFT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IRQ,
  input  logic [3:0]  IC,
  input  logic        IE,
  input  logic        INT_ACK,
  input  logic        EOI,
`ifdef IRQ_MASK_EN
  input  logic        MASK_WE,
  input  logic [15:0] MASK_DIN,
`endif
  output logic        INT_REQ,
  output logic [15:0] VEC,
  output logic [3:0]  ACTIVE,
  output logic        IN_SVC,
  output logic [15:0] PENDING
);

  localparam int unsigned NCODE = 16;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    sel_q, sel_d;
  logic             int_req_q, int_req_d;
  logic [15:0]      vec_q, vec_d;
  logic [CW-1:0]    active_q, active_d;
  logic             in_svc_q, in_svc_d;
  logic [NCODE-1:0] pending_q, pending_d;

  logic [NCODE-1:0] mask_w;
  logic [NCODE-1:0] eligible;
  logic             any_elig;
  logic [CW-1:0]    first_idx;
  logic [15:0]      first_vec;
  logic [NCODE-1:0] clr_bits;
  logic [NCODE-1:0] set_bits;

`ifdef IRQ_MASK_EN
  logic [NCODE-1:0] mask_q, mask_d;

  // Mask load; new value takes part in selection from the following cycle.
  always_comb begin
    mask_d = mask_q;
    if (MASK_WE) mask_d = MASK_DIN;
  end

  // Mask register, all codes enabled out of reset.
  always_ff @(posedge CLK) begin
    if (RST) mask_q <= 16'hFFFF;
    else     mask_q <= mask_d;
  end

  assign mask_w = mask_q;
`else
  localparam logic [NCODE-1:0] MASK_ALL = 16'hFFFF;
  assign mask_w = MASK_ALL;
`endif

  // Lowest-index eligible code wins; its vector wraps modulo 2^16.
  always_comb begin
    eligible  = pending_q & mask_w;
    any_elig  = |eligible;
    first_idx = '0;
    for (int i = NCODE - 1; i >= 0; i--) begin
      if (eligible[i]) first_idx = CW'(i);
    end
    first_vec = VEC_BASE + (16'(first_idx) << VEC_SHIFT);
  end

  // Next-state, output and pending-bit logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    int_req_d = int_req_q;
    vec_d     = vec_q;
    active_d  = active_q;
    in_svc_d  = in_svc_q;
    clr_bits  = '0;
    set_bits  = '0;

    case (state_q)
      IDLE: begin
        if (IE && any_elig) begin
          state_d   = REQ;
          sel_d     = first_idx;
          int_req_d = 1'b1;
          vec_d     = first_vec;
        end
      end
      REQ: begin
        if (INT_ACK) begin
          state_d   = SERVICE;
          clr_bits  = NCODE'(1) << sel_q;
          active_d  = sel_q;
          in_svc_d  = 1'b1;
          int_req_d = 1'b0;
        end else if (!IE || !mask_w[sel_q]) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end
      end
      SERVICE: begin
        if (EOI) begin
          state_d  = IDLE;
          in_svc_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
        in_svc_d  = 1'b0;
      end
    endcase

    // A strobe arriving with the ack of the same code re-arms it.
    if (IRQ) set_bits = NCODE'(1) << IC;
    pending_d = (pending_q & ~clr_bits) | set_bits;
  end

  // State and output registers; reset discards everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      int_req_q <= 1'b0;
      vec_q     <= '0;
      active_q  <= '0;
      in_svc_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      int_req_q <= int_req_d;
      vec_q     <= vec_d;
      active_q  <= active_d;
      in_svc_q  <= in_svc_d;
      pending_q <= pending_d;
    end
  end

  assign INT_REQ = int_req_q;
  assign VEC     = vec_q;
  assign ACTIVE  = active_q;
  assign IN_SVC  = in_svc_q;
  assign PENDING = pending_q;

endmodule
